// File: rtl/qpm_pkg.sv
// qpm_pkg: shared sizing constants, FSM encoding and address helpers for the
// query-patch store (banked 32x256 1rw1r SRAM macros).
package qpm_pkg;

  localparam int QPM_DATA_WIDTH = 11;
  localparam int QPM_PATCH_SIZE = 5;
  localparam int QPM_ADDR_WIDTH = 9;
  localparam int QPM_MACRO_DW   = 32;

  // Every macro is 256 rows deep, so the low 8 address bits pick the row.
  localparam int ROW_BITS   = 8;
  localparam int MACRO_ROWS = 256;

  function automatic int calc_pw(input int dw, input int ps);
    return dw * ps;
  endfunction

  function automatic int calc_nb(input int aw);
    return 1 << (aw - ROW_BITS);
  endfunction

  function automatic int calc_nw(input int pw, input int mdw);
    return (pw + mdw - 1) / mdw;
  endfunction

  function automatic int calc_pad(input int pw, input int mdw);
    return calc_nw(pw, mdw) * mdw - pw;
  endfunction

  // A single-bank build still carries a 1-bit select so vectors never collapse to zero width.
  function automatic int calc_bank_w(input int aw);
    return (aw > ROW_BITS) ? (aw - ROW_BITS) : 1;
  endfunction

  localparam int PW    = calc_pw(QPM_DATA_WIDTH, QPM_PATCH_SIZE);
  localparam int NB    = calc_nb(QPM_ADDR_WIDTH);
  localparam int NW    = calc_nw(PW, QPM_MACRO_DW);
  localparam int PAD_W = calc_pad(PW, QPM_MACRO_DW);

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_FILL = 2'd1,
    WR_FULL = 2'd2
  } wr_state_e;

  // Upper address bits select the bank.
  function automatic logic [31:0] bank_of(input logic [31:0] addr);
    return addr >> ROW_BITS;
  endfunction

  // Lower address bits select the row inside every macro of a bank.
  function automatic logic [ROW_BITS-1:0] row_of(input logic [31:0] addr);
    return ROW_BITS'(addr % MACRO_ROWS);
  endfunction

endpackage

// File: rtl/qpm_bank.sv
// qpm_bank: one bank of NW side-by-side 32x256 1rw1r macros. The patch is
// zero-padded up to NW*MDW bits and sliced across the macros; the macro read
// registers are concatenated back into a patch. Port 0 is read/write, port 1
// is read-only; both have one cycle of latency and active-low chip selects.
// A port-1 read of a row being written on port 0 in the same cycle returns the
// previous contents, as the real macro does. Writes always use a full mask.
module qpm_bank
  import qpm_pkg::*;
#(
  parameter int PW_P = PW,
  parameter int NW_P = NW,
  parameter int MDW  = QPM_MACRO_DW
) (
  input  logic                clk,
  input  logic                csb0,
  input  logic                web0,
  input  logic [ROW_BITS-1:0] addr0,
  input  logic [PW_P-1:0]     din0,
  output logic [PW_P-1:0]     dout0,
  input  logic                csb1,
  input  logic [ROW_BITS-1:0] addr1,
  output logic [PW_P-1:0]     dout1
);

  localparam int FULL_W = NW_P * MDW;

  logic [FULL_W-1:0] din_full;

  // Pad bits above the patch are stored as zeros.
  assign din_full = FULL_W'(din0);

  for (genvar w = 0; w < NW_P; w++) begin : g_macro
    localparam int LO   = w * MDW;
    localparam int USED = ((PW_P - LO) < MDW) ? (PW_P - LO) : MDW;

    logic [MDW-1:0]  mem [MACRO_ROWS];
    logic [USED-1:0] q0;
    logic [USED-1:0] q1;

    // Macro core: port 0 writes or reads, port 1 reads; contents are never reset.
    always_ff @(posedge clk) begin
      if (!csb0) begin
        if (!web0) begin
          mem[addr0] <= din_full[LO +: MDW];
        end else begin
          q0 <= mem[addr0][USED-1:0];
        end
      end
      if (!csb1) begin
        q1 <= mem[addr1][USED-1:0];
      end
    end

    assign dout0[LO +: USED] = q0;
    assign dout1[LO +: USED] = q1;
  end

endmodule

// File: rtl/query_patch_mem_banked.sv
// query_patch_mem_banked: banked query-patch store between the query loader
// and the kd-tree leaf compare stage. Port A takes a streamed write channel
// with an auto-incrementing address and also serves random reads (writes win
// the shared 1rw port); port B is a dedicated read port. Both read ports have
// a fixed 2-cycle latency: request -> macro read register -> output register.
// The bank a read went to travels with it down the pipeline so the output mux
// never looks at the live request address.
// Optional feature macro QPM_RAW_FWD_EN: when defined, a port-B read of the
// address being written in the same cycle returns the incoming write patch
// through the same 2-stage pipeline; otherwise it returns the old contents.
module query_patch_mem_banked
  import qpm_pkg::*;
#(
  parameter int DATA_WIDTH = QPM_DATA_WIDTH,
  parameter int PATCH_SIZE = QPM_PATCH_SIZE,
  parameter int ADDR_WIDTH = QPM_ADDR_WIDTH,
  parameter int MACRO_DW   = QPM_MACRO_DW
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_start,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [DATA_WIDTH*PATCH_SIZE-1:0] wr_patch,
  output logic [ADDR_WIDTH:0]              wr_count,
  output logic                             wr_full,
  input  logic                             rda_valid,
  output logic                             rda_ready,
  input  logic [ADDR_WIDTH-1:0]            rda_addr,
  output logic                             rda_dvalid,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0] rda_patch,
  input  logic                             rdb_valid,
  input  logic [ADDR_WIDTH-1:0]            rdb_addr,
  output logic                             rdb_dvalid,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0] rdb_patch
);

  localparam int PWL    = calc_pw(DATA_WIDTH, PATCH_SIZE);
  localparam int NBL    = calc_nb(ADDR_WIDTH);
  localparam int NWL    = calc_nw(PWL, MACRO_DW);
  localparam int BANK_W = calc_bank_w(ADDR_WIDTH);

  // Count value of the final entry; accepting it fills the store.
  localparam logic [ADDR_WIDTH:0] LAST_CNT = {1'b0, {ADDR_WIDTH{1'b1}}};

  wr_state_e             state_q;
  wr_state_e             state_d;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   count_d;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_accept;
  logic                  rda_accept;

  logic [ADDR_WIDTH-1:0] a_addr;
  logic                  a_en;
  logic [BANK_W-1:0]     a_bank;
  logic [BANK_W-1:0]     b_bank;

  logic [PWL-1:0]        douta [NBL];
  logic [PWL-1:0]        doutb [NBL];

  logic                  a_vld_s1;
  logic                  b_vld_s1;
  logic [BANK_W-1:0]     a_sel_s1;
  logic [BANK_W-1:0]     b_sel_s1;
  logic [PWL-1:0]        b_data_s2;

  // A restart always blocks the write offered in the same cycle.
  assign wr_full    = (state_q == WR_FULL);
  assign wr_ready   = !wr_full && !wr_start;
  assign wr_accept  = wr_valid && wr_ready;
  assign rda_ready  = !wr_accept;
  assign rda_accept = rda_valid && rda_ready;
  assign wr_count   = count_q;
  assign wr_addr    = count_q[ADDR_WIDTH-1:0];

  // Write-counter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WR_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Restart wins; otherwise advance on each accepted patch and stop (no wrap) at full.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (wr_start) begin
      state_d = WR_IDLE;
      count_d = '0;
    end else if (wr_accept) begin
      count_d = count_q + 1'b1;
      state_d = (count_q == LAST_CNT) ? WR_FULL : WR_FILL;
    end
  end

  // Port A carries the write when one is accepted, otherwise the random read.
  assign a_addr = wr_accept ? wr_addr : rda_addr;
  assign a_en   = wr_accept || rda_accept;
  assign a_bank = BANK_W'(bank_of(32'(a_addr)));
  assign b_bank = BANK_W'(bank_of(32'(rdb_addr)));

  for (genvar b = 0; b < NBL; b++) begin : g_bank
    logic csb0;
    logic csb1;

    assign csb0 = !(a_en && (a_bank == BANK_W'(b)));
    assign csb1 = !(rdb_valid && (b_bank == BANK_W'(b)));

    qpm_bank #(
      .PW_P (PWL),
      .NW_P (NWL),
      .MDW  (MACRO_DW)
    ) u_bank (
      .clk   (clk),
      .csb0  (csb0),
      .web0  (!wr_accept),
      .addr0 (row_of(32'(a_addr))),
      .din0  (wr_patch),
      .dout0 (douta[b]),
      .csb1  (csb1),
      .addr1 (row_of(32'(rdb_addr))),
      .dout1 (doutb[b])
    );
  end

  // Stage 1: remember which reads were issued and which bank each went to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_vld_s1 <= 1'b0;
      b_vld_s1 <= 1'b0;
      a_sel_s1 <= '0;
      b_sel_s1 <= '0;
    end else begin
      a_vld_s1 <= rda_accept;
      b_vld_s1 <= rdb_valid;
      if (rda_accept) begin
        a_sel_s1 <= a_bank;
      end
      if (rdb_valid) begin
        b_sel_s1 <= b_bank;
      end
    end
  end

`ifdef QPM_RAW_FWD_EN
  logic           b_fwd_s1;
  logic [PWL-1:0] b_fwd_data_s1;

  // Stage 1 forwarding: flag a port-B read that hits the row being written this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_fwd_s1      <= 1'b0;
      b_fwd_data_s1 <= '0;
    end else begin
      b_fwd_s1 <= rdb_valid && wr_accept && (rdb_addr == wr_addr);
      if (rdb_valid && wr_accept && (rdb_addr == wr_addr)) begin
        b_fwd_data_s1 <= wr_patch;
      end
    end
  end

  assign b_data_s2 = b_fwd_s1 ? b_fwd_data_s1 : doutb[b_sel_s1];
`else
  assign b_data_s2 = doutb[b_sel_s1];
`endif

  // Stage 2: register the selected bank's data; patches hold between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rda_dvalid <= 1'b0;
      rdb_dvalid <= 1'b0;
      rda_patch  <= '0;
      rdb_patch  <= '0;
    end else begin
      rda_dvalid <= a_vld_s1;
      rdb_dvalid <= b_vld_s1;
      if (a_vld_s1) begin
        rda_patch <= douta[a_sel_s1];
      end
      if (b_vld_s1) begin
        rdb_patch <= b_data_s2;
      end
    end
  end

endmodule
